// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. Multiplies by shift-add on
//   operand magnitudes and divides by restoring division, UNROLL radix-2 steps
//   per cycle, followed by one sign-fix cycle. Divide-by-zero and signed
//   overflow are resolved at accept and skip the iteration entirely.
//
// Parameters
//   XLEN   : operand/result width (32 or 64)
//   UNROLL : radix-2 steps per CALC cycle (1, 2 or 4; must divide XLEN)
//
// Ports
//   pll_1_200MHz   in   clock, all state on the rising edge
//   system_reset_n in   asynchronous active-low reset
//   flush          in   abandon the current operation, return to IDLE
//   in_valid       in   request present
//   in_ready       out  unit idle and able to accept
//   funct3         in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                       100 DIV 101 DIVU 110 REM  111 REMU
//   operand_a      in   rs1 (multiplicand / dividend)
//   operand_b      in   rs2 (multiplier / divisor)
//   out_valid      out  result present (only in DONE)
//   out_ready      in   consumer takes the result
//   result         out  operation result, held stable in DONE
//   busy           out  state is not IDLE
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            pll_1_200MHz,
  input  logic            system_reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                neg_main;   // negate product / quotient at FIX
  logic                neg_rem;    // negate remainder at FIX
  logic [2*XLEN-1:0]   acc;        // {hi, lo}: product, or {remainder, quotient}
  logic [2*XLEN-1:0]   acc_next;
  logic [XLEN-1:0]     fix_result;

  // Accept-time decode of the incoming request.
  logic            is_div_in;
  logic            signed_div_in;
  logic            sign_a_in;
  logic            sign_b_in;
  logic [XLEN-1:0] abs_a_in;
  logic [XLEN-1:0] abs_b_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_result;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0]   m);
    logic [XLEN:0] sum;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[XLEN-1:1]};
  endfunction

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder, keep the difference only if the divisor fits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    trial = p[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, d};
    // A clear top bit means no borrow, i.e. trial >= divisor.
    if (!diff[XLEN]) return {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else             return {trial[XLEN-1:0], p[XLEN-2:0], 1'b0};
  endfunction

  always_comb begin
    // NOTE: combinational blocks assign every output a default first and use
    // blocking assignments, so no latch is inferred and the chain of steps
    // below evaluates in order within the cycle.
    is_div_in     = funct3[2];
    signed_div_in = funct3[2] & ~funct3[0];
    sign_a_in     = is_div_in ? (signed_div_in & operand_a[XLEN-1])
                              : (((funct3 == OP_MULH) || (funct3 == OP_MULHSU)) & operand_a[XLEN-1]);
    sign_b_in     = is_div_in ? (signed_div_in & operand_b[XLEN-1])
                              : ((funct3 == OP_MULH) & operand_b[XLEN-1]);
    abs_a_in      = sign_a_in ? (XLEN'(0) - operand_a) : operand_a;
    abs_b_in      = sign_b_in ? (XLEN'(0) - operand_b) : operand_b;
    div_zero      = is_div_in && (operand_b == '0);
    div_ovf       = signed_div_in && (operand_a == MIN_NEG) && (operand_b == '1);
    if (div_zero) special_result = funct3[1] ? operand_a : '1;
    else          special_result = funct3[1] ? '0 : operand_a;
  end

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < UNROLL; i++) begin
      acc_next = op[2] ? div_step(acc_next, mag_b) : mul_step(acc_next, mag_a);
    end
  end

  always_comb begin
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg_main ? ((2*XLEN)'(0) - acc) : acc;
    quo  = neg_main ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_rem  ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    if (op[2])              fix_result = op[1] ? rem : quo;
    else if (op == OP_MUL)  fix_result = prod[XLEN-1:0];
    else                    fix_result = prod[2*XLEN-1:XLEN];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: every register, datapath included, is cleared by the asynchronous
  // reset and updated with non-blocking assignments, so all state changes
  // together on the edge and nothing is ever X after reset.
  always_ff @(posedge pll_1_200MHz or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op       <= funct3;
            mag_a    <= abs_a_in;
            mag_b    <= abs_b_in;
            neg_main <= sign_a_in ^ sign_b_in;
            neg_rem  <= sign_a_in;
            acc      <= {{XLEN{1'b0}}, (is_div_in ? abs_a_in : abs_b_in)};
            if (div_zero || div_ovf) begin
              result    <= special_result;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= CNT_W'(STEPS);
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          result    <= fix_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Two instances share clock, reset and
//   request fields: u1 (XLEN=32, UNROLL=1) and u4 (XLEN=32, UNROLL=4).
//   Expected results come from plain SystemVerilog arithmetic on the RV32M
//   rules; a compare process checks both instances every cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iv1 = 1'b0;
  logic        iv4 = 1'b0;
  logic        ordy = 1'b0;
  logic [2:0]  f = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        ir1, ov1, bz1;
  logic [31:0] res1;
  logic        ir4, ov4, bz4;
  logic [31:0] res4;

  int n_checks = 0;
  int n_fail   = 0;

  bit          pend   [2];
  logic [31:0] sb_exp [2];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .pll_1_200MHz(clk), .system_reset_n(rst_n), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .funct3(f), .operand_a(a), .operand_b(b),
    .out_valid(ov1), .out_ready(ordy), .result(res1), .busy(bz1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .pll_1_200MHz(clk), .system_reset_n(rst_n), .flush(flush),
    .in_valid(iv4), .in_ready(ir4), .funct3(f), .operand_a(a), .operand_b(b),
    .out_valid(ov4), .out_ready(ordy), .result(res4), .busy(bz4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32M semantics straight from integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] x,
                                        input logic [31:0] y);
    logic        [63:0] ux = {32'b0, x};
    logic        [63:0] uy = {32'b0, y};
    logic signed [63:0] sx = 64'(signed'(x));
    logic signed [63:0] sy = 64'(signed'(y));
    logic        [63:0] pu;
    logic signed [63:0] ps;
    logic signed [31:0] qs;
    case (fn)
      3'd0: begin pu = ux * uy; return pu[31:0];  end
      3'd1: begin ps = sx * sy; return ps[63:32]; end
      3'd2: begin ps = sx * signed'(uy); return ps[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return x;
        qs = signed'(x) / signed'(y);
        return qs;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'h0;
        qs = signed'(x) % signed'(y);
        return qs;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] fn, input logic [31:0] x,
                                    input logic [31:0] y);
    return fn[2] && ((y == 0) || (!fn[0] && x == MIN_NEG && y == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_NEG;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request to instance sel (0 = u1, 1 = u4), check its latency and
  // result, hold it in DONE for `hold` cycles, then consume it.
  task automatic run_op(input bit sel, input string name, input logic [2:0] fn,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int hold);
    int          lat;
    int          exp_lat;
    logic [31:0] held;
    exp_lat = is_special(fn, x, y) ? 1 : XLEN / (sel ? 4 : 1) + 2;
    f = fn; a = x; b = y;
    check({name, "_in_ready"}, 64'(sel ? ir4 : ir1), 64'(1));
    sb_exp[sel] = exp;
    pend[sel]   = 1'b1;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    lat = 1;
    while (!(sel ? ov4 : ov1) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, 64'(sel ? res4 : res1), 64'(exp));
    held = sel ? res4 : res1;
    repeat (hold) begin
      @(posedge clk); #1;
      check({name, "_hold_result"}, 64'(sel ? res4 : res1), 64'(held));
      check({name, "_hold_valid"}, 64'(sel ? ov4 : ov1), 64'(1));
      check({name, "_hold_in_ready"}, 64'(sel ? ir4 : ir1), 64'(0));
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    pend[sel] = 1'b0;
    check({name, "_exit_valid"}, 64'(sel ? ov4 : ov1), 64'(0));
    check({name, "_exit_in_ready"}, 64'(sel ? ir4 : ir1), 64'(1));
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_in_ready"}, 64'(ir1), 64'(1));
    check({name, "_out_valid"}, 64'(ov1), 64'(0));
    check({name, "_busy"}, 64'(bz1), 64'(0));
    check({name, "_result"}, 64'(res1), 64'(0));
    check({name, "_u4_in_ready"}, 64'(ir4), 64'(1));
    check({name, "_u4_out_valid"}, 64'(ov4), 64'(0));
    check({name, "_u4_result"}, 64'(res4), 64'(0));
  endtask

  // Compare process: every cycle, outputs must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1) check("cmp_u1_result", 64'(res1), 64'(sb_exp[0]));
      if (!pend[0]) check("cmp_u1_spurious_valid", 64'(ov1), 64'(0));
      check("cmp_u1_ready_vs_busy", 64'(ir1), 64'(!bz1));
      if (ov4) check("cmp_u4_result", 64'(res4), 64'(sb_exp[1]));
      if (!pend[1]) check("cmp_u4_spurious_valid", 64'(ov4), 64'(0));
      check("cmp_u4_ready_vs_busy", 64'(ir4), 64'(!bz4));
    end
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    pend[0] = 1'b0; pend[1] = 1'b0;
    sb_exp[0] = '0; sb_exp[1] = '0;

    // Pin the reference model with hand-computed values.
    check("model_mulh",   64'(model(3'd1, MIN_NEG, MIN_NEG)),           64'h4000_0000);
    check("model_mulhsu", 64'(model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
    check("model_div",    64'(model(3'd4, 32'hFFFF_FFF9, 32'd2)),       64'hFFFF_FFFD);
    check("model_rem",    64'(model(3'd6, 32'hFFFF_FFF9, 32'd2)),       64'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed cases with literal expectations.
    run_op(0, "mulh_min",   3'd1, MIN_NEG, MIN_NEG, 32'h4000_0000, 0);
    run_op(0, "mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(0, "mulhsu_ones",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, "mul_neg",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(0, "div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op(0, "rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(0, "divu",       3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op(0, "remu",       3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op(0, "divu_zero",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(0, "remu_zero",  3'd7, 32'd5, 32'd0, 32'd5, 0);
    run_op(0, "div_ovf",    3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 0);
    run_op(0, "rem_ovf",    3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 0);
    run_op(0, "hold_done",  3'd0, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 10);
    run_op(1, "u4_mul",     3'd0, 32'h1234_5678, 32'd9, 32'hA3D7_0A38, 0);

    // Flush during the fifth CALC cycle: no result may ever appear.
    f = 3'd0; a = 32'h0BAD_CAFE; b = 32'h0000_1234;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    check("flush_busy_before", 64'(bz1), 64'(1));
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 64'(ov1), 64'(0));
    check("flush_in_ready", 64'(ir1), 64'(1));
    check("flush_busy", 64'(bz1), 64'(0));
    repeat (40) @(posedge clk);
    #1;

    // Flush coincident with a request in IDLE blocks acceptance.
    flush = 1'b1; iv1 = 1'b1; iv4 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; iv1 = 1'b0; iv4 = 1'b0;
    check("flush_idle_busy", 64'(bz1), 64'(0));
    check("flush_idle_u4_busy", 64'(bz4), 64'(0));
    repeat (12) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    f = 3'd5; a = 32'hDEAD_BEEF; b = 32'd3;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid_calc");
    @(posedge clk); #1;
    check_reset_state("reset_held");
    rst_n = 1'b1;
    run_op(0, "post_reset", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op(0, "rand_u1", rf, ra, rb, model(rf, ra, rb), $urandom_range(0, 2));
    end
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op(1, "rand_u4", rf, ra, rb, model(rf, ra, rb), $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
